// File: rtl/io_port_ctrl.sv
// External-side peer of the core I/O port: TX FIFO toward a valid/ready sink, RX holding register
// feeding the core `in` bus. Define IO_RX_INT_EN to build the receive-interrupt FSM.
module io_port_ctrl #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned TX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] cpu_out_data,
    input  logic              cpu_out_wr,
    output logic [DATA_W-1:0] cpu_in_data,
    output logic              cpu_in_valid,
    input  logic              cpu_in_rd,
    output logic              int_req,
    input  logic              int_ack,
    output logic [DATA_W-1:0] ext_tx_data,
    output logic              ext_tx_valid,
    input  logic              ext_tx_ready,
    input  logic [DATA_W-1:0] ext_rx_data,
    input  logic              ext_rx_valid,
    output logic              ext_rx_ready,
    output logic              tx_full,
    output logic              tx_ovf
);

    localparam int unsigned PTR_W = $clog2(TX_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] txMem [TX_DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  txCount;
    logic              txOvfReg;
    logic              txPush;
    logic              txPop;

    logic [DATA_W-1:0] inDataReg;
    logic              inValidReg;
    logic              rxCapture;
    logic              rdAccept;

    // ------------------------------------------------------------------ TX FIFO
    assign ext_tx_valid = (txCount != '0);
    assign tx_full      = (txCount == CNT_W'(TX_DEPTH));
    assign tx_ovf       = txOvfReg;
    assign txPop        = ext_tx_valid && ext_tx_ready;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign txPush       = cpu_out_wr && (!tx_full || txPop);
    assign ext_tx_data  = ext_tx_valid ? txMem[rdPtr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            txCount  <= '0;
            txOvfReg <= 1'b0;
        end else begin
            if (txPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (txPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (txPush && !txPop) begin
                txCount <= txCount + CNT_W'(1);
            end else if (txPop && !txPush) begin
                txCount <= txCount - CNT_W'(1);
            end
            if (cpu_out_wr && !txPush) begin
                txOvfReg <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (txPush) begin
            txMem[wrPtr] <= cpu_out_data;
        end
    end

    // ------------------------------------------------------------------ RX holding register
    assign ext_rx_ready = !inValidReg;
    assign rxCapture    = ext_rx_valid && ext_rx_ready;
    assign rdAccept     = cpu_in_rd && inValidReg;
    assign cpu_in_data  = inDataReg;
    assign cpu_in_valid = inValidReg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inDataReg  <= '0;
            inValidReg <= 1'b0;
        end else if (rxCapture) begin
            inDataReg  <= ext_rx_data;
            inValidReg <= 1'b1;
        end else if (rdAccept) begin
            inValidReg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------ receive interrupt
`ifdef IO_RX_INT_EN
    typedef enum logic [1:0] {
        IntIdle,
        IntReq,
        IntAckd
    } intState_t;

    intState_t intState;
    intState_t intStateNext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            intState <= IntIdle;
        end else begin
            intState <= intStateNext;
        end
    end

    always_comb begin
        intStateNext = intState;
        unique case (intState)
            IntIdle: begin
                if (rxCapture) begin
                    intStateNext = IntReq;
                end
            end
            IntReq: begin
                // A read before the ack withdraws the request.
                if (rdAccept) begin
                    intStateNext = IntIdle;
                end else if (int_ack) begin
                    intStateNext = IntAckd;
                end
            end
            IntAckd: begin
                if (rdAccept) begin
                    intStateNext = IntIdle;
                end
            end
            default: intStateNext = IntIdle;
        endcase
    end

    assign int_req = (intState == IntReq);
`else
    logic unusedIntAck;
    assign unusedIntAck = int_ack;
    assign int_req      = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl: TX FIFO ordering/full/overflow, RX holding register,
// optional receive interrupt, and asynchronous reset in mid-transfer.
module tb_io_port_ctrl;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned TX_DEPTH = 4;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] cpu_out_data;
    logic              cpu_out_wr;
    logic [DATA_W-1:0] cpu_in_data;
    logic              cpu_in_valid;
    logic              cpu_in_rd;
    logic              int_req;
    logic              int_ack;
    logic [DATA_W-1:0] ext_tx_data;
    logic              ext_tx_valid;
    logic              ext_tx_ready;
    logic [DATA_W-1:0] ext_rx_data;
    logic              ext_rx_valid;
    logic              ext_rx_ready;
    logic              tx_full;
    logic              tx_ovf;

    int checks = 0;
    int errors = 0;

    io_port_ctrl #(
        .DATA_W  (DATA_W),
        .TX_DEPTH(TX_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_out_data(cpu_out_data),
        .cpu_out_wr  (cpu_out_wr),
        .cpu_in_data (cpu_in_data),
        .cpu_in_valid(cpu_in_valid),
        .cpu_in_rd   (cpu_in_rd),
        .int_req     (int_req),
        .int_ack     (int_ack),
        .ext_tx_data (ext_tx_data),
        .ext_tx_valid(ext_tx_valid),
        .ext_tx_ready(ext_tx_ready),
        .ext_rx_data (ext_rx_data),
        .ext_rx_valid(ext_rx_valid),
        .ext_rx_ready(ext_rx_ready),
        .tx_full     (tx_full),
        .tx_ovf      (tx_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, " cpu_in_data"}, 32'(cpu_in_data), 32'h0);
        check({tag, " cpu_in_valid"}, 32'(cpu_in_valid), 32'h0);
        check({tag, " int_req"}, 32'(int_req), 32'h0);
        check({tag, " ext_tx_valid"}, 32'(ext_tx_valid), 32'h0);
        check({tag, " ext_tx_data"}, 32'(ext_tx_data), 32'h0);
        check({tag, " ext_rx_ready"}, 32'(ext_rx_ready), 32'h1);
        check({tag, " tx_full"}, 32'(tx_full), 32'h0);
        check({tag, " tx_ovf"}, 32'(tx_ovf), 32'h0);
    endtask

    logic [15:0] drainExp [4];

    initial begin
        rst          = 1'b1;
        cpu_out_data = '0;
        cpu_out_wr   = 1'b0;
        cpu_in_rd    = 1'b0;
        int_ack      = 1'b0;
        ext_tx_ready = 1'b0;
        ext_rx_data  = '0;
        ext_rx_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // 1. Three OUT writes streaming through with the sink ready.
        ext_tx_ready = 1'b1;
        cpu_out_wr   = 1'b1;
        cpu_out_data = 16'h0011;
        cyc();
        check("t1 valid after 1st strobe", 32'(ext_tx_valid), 32'h1);
        check("t1 data 1st", 32'(ext_tx_data), 32'h0011);
        cpu_out_data = 16'h0022;
        cyc();
        check("t1 data 2nd", 32'(ext_tx_data), 32'h0022);
        cpu_out_data = 16'h0033;
        cyc();
        check("t1 data 3rd", 32'(ext_tx_data), 32'h0033);
        check("t1 full stays 0", 32'(tx_full), 32'h0);
        cpu_out_wr = 1'b0;
        cyc();
        check("t1 empty after drain", 32'(ext_tx_valid), 32'h0);

        // 3. Fill to full with the sink stalled, then push+pop while full.
        ext_tx_ready = 1'b0;
        cpu_out_wr   = 1'b1;
        cpu_out_data = 16'h00A1;
        cyc();
        cpu_out_data = 16'h00A2;
        cyc();
        cpu_out_data = 16'h00A3;
        cyc();
        check("t3 not full at 3", 32'(tx_full), 32'h0);
        check("t3 head stable while stalled", 32'(ext_tx_data), 32'h00A1);
        cpu_out_data = 16'h00A4;
        cyc();
        check("t3 full at 4", 32'(tx_full), 32'h1);
        ext_tx_ready = 1'b1;
        cpu_out_data = 16'h00B5;
        cyc();
        check("t3 full after push+pop", 32'(tx_full), 32'h1);
        check("t3 no ovf on push+pop", 32'(tx_ovf), 32'h0);
        check("t3 head advanced", 32'(ext_tx_data), 32'h00A2);

        // 2. Write into a full, stalled FIFO: word dropped, sticky overflow.
        ext_tx_ready = 1'b0;
        cpu_out_data = 16'h00A6;
        cyc();
        check("t2 ovf set", 32'(tx_ovf), 32'h1);
        check("t2 still full", 32'(tx_full), 32'h1);
        cpu_out_wr = 1'b0;
        cyc();
        check("t2 ovf sticky", 32'(tx_ovf), 32'h1);

        drainExp[0] = 16'h00A2;
        drainExp[1] = 16'h00A3;
        drainExp[2] = 16'h00A4;
        drainExp[3] = 16'h00B5;
        ext_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain valid %0d", i), 32'(ext_tx_valid), 32'h1);
            check($sformatf("drain data %0d", i), 32'(ext_tx_data), 32'(drainExp[i]));
            cyc();
        end
        check("drain empty", 32'(ext_tx_valid), 32'h0);
        ext_tx_ready = 1'b0;

        // 4. RX capture, back-pressure on the second word, release on read.
        check("t4 ready before", 32'(ext_rx_ready), 32'h1);
        ext_rx_valid = 1'b1;
        ext_rx_data  = 16'hBEEF;
        cyc();
        check("t4 data captured", 32'(cpu_in_data), 32'hBEEF);
        check("t4 valid set", 32'(cpu_in_valid), 32'h1);
        check("t4 ready low", 32'(ext_rx_ready), 32'h0);
`ifdef IO_RX_INT_EN
        check("t5 int_req after capture", 32'(int_req), 32'h1);
`else
        check("t5 int_req tied low", 32'(int_req), 32'h0);
`endif
        ext_rx_data = 16'h1234;
        int_ack     = 1'b1;
        cyc();
        int_ack = 1'b0;
        check("t4 second word stalled", 32'(cpu_in_data), 32'hBEEF);
        check("t5 int_req after ack", 32'(int_req), 32'h0);
        cpu_in_rd = 1'b1;
        cyc();
        cpu_in_rd = 1'b0;
        check("t4 valid cleared by rd", 32'(cpu_in_valid), 32'h0);
        check("t4 data held after rd", 32'(cpu_in_data), 32'hBEEF);
        check("t4 ready back", 32'(ext_rx_ready), 32'h1);
        cyc();
        check("t4 second word captured", 32'(cpu_in_data), 32'h1234);
        check("t4 valid again", 32'(cpu_in_valid), 32'h1);
        ext_rx_valid = 1'b0;
`ifdef IO_RX_INT_EN
        check("t5 int_req re-raised", 32'(int_req), 32'h1);
`else
        check("t5 int_req still low", 32'(int_req), 32'h0);
`endif
        // Read while the request is pending withdraws it.
        cpu_in_rd = 1'b1;
        cyc();
        check("t5 int_req withdrawn", 32'(int_req), 32'h0);
        check("t4 valid cleared 2", 32'(cpu_in_valid), 32'h0);
        cyc();
        cpu_in_rd = 1'b0;
        check("t4 rd on empty ignored", 32'(cpu_in_valid), 32'h0);
        check("t4 data kept on empty rd", 32'(cpu_in_data), 32'h1234);

        // 6. Asynchronous reset with words queued and an interrupt pending.
        cpu_out_wr   = 1'b1;
        cpu_out_data = 16'h0C01;
        ext_rx_valid = 1'b1;
        ext_rx_data  = 16'h5A5A;
        cyc();
        cpu_out_data = 16'h0C02;
        ext_rx_valid = 1'b0;
        cyc();
        cpu_out_wr = 1'b0;
        check("t6 queued valid", 32'(ext_tx_valid), 32'h1);
        check("t6 rx held", 32'(cpu_in_data), 32'h5A5A);
`ifdef IO_RX_INT_EN
        check("t6 int pending", 32'(int_req), 32'h1);
`endif
        #2 rst = 1'b0;
        #1;
        checkResetOutputs("t6 async");
        @(negedge clk);
        rst = 1'b1;
        cyc();
        check("t6 no stale tx", 32'(ext_tx_valid), 32'h0);
        check("t6 no stale data", 32'(ext_tx_data), 32'h0);
        check("t6 rx empty", 32'(cpu_in_valid), 32'h0);
        check("t6 ovf clear", 32'(tx_ovf), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
